ahb_mem_slave: RTL and testbench
================================

# ahb_mem_slave

AHB-Lite word-organised SRAM slave with a configurable number of wait states and the two-cycle ERROR response. One instance drives one slave leg (hrdata_n / hreadyout_n / hresp_n) of the slave-to-master read-data/response multiplexer. Its hready input is that multiplexer's hreadyout output.

## Interface
- ADDR_WIDTH, 8, word-address bits; memory depth = 2**ADDR_WIDTH 32-bit words; byte address bits used = ADDR_WIDTH+2, upper haddr bits ignored.
- WAIT_STATES, 1, hreadyout-low cycles inserted before every OKAY data phase completes; legal range 0..15.
- hclk  in  1  bus clock; all state updates on rising edge.
- hreset  in  1  synchronous, active-high reset.
- hsel  in  1  slave select from address decoder.
- haddr  in  32  byte address (address phase).
- htrans  in  2  transfer type; htrans[1]=1 means NONSEQ/SEQ.
- hwrite  in  1  1=write, 0=read.
- hsize  in  3  0=byte, 1=halfword, 2=word; >2 is illegal.
- hwdata  in  32  write data (data phase), little-endian byte lanes.
- hready  in  1  bus ready from read-data multiplexer.
- hrdata  out  32  read data.
- hreadyout  out  1  slave ready.
- hresp  out  1  0=OKAY, 1=ERROR.

## Operation
- Accept: at a rising edge with hsel & htrans[1] & hready = 1. Capture haddr, hwrite and hsize. No other combination starts a transfer. IDLE/BUSY transfers get a zero-wait OKAY.
- Error check at accept. ERROR if any of:
  - hsize > 2
  - hsize = 1 and haddr[0] = 1
  - hsize = 2 and haddr[1:0] != 0
- States:
  - IDLE: hreadyout=1, hresp=0.
  - WAIT: hreadyout=0, hresp=0; counter runs.
  - DATA: hreadyout=1, hresp=0; completing cycle.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- Transitions:
  - Accepted with error → ERR1 → ERR2.
  - Accepted OKAY with WAIT_STATES=0 → DATA.
  - Accepted OKAY with WAIT_STATES>0 → WAIT; wait counter loaded with WAIT_STATES-1; WAIT → DATA when counter = 0.
  - From DATA, ERR2 or IDLE: a new accept follows the rules above; otherwise → IDLE.
- Write commit: memory is updated at the edge ending the DATA cycle, from hwdata. Only the lanes selected by hsize and haddr[1:0] are written; other bytes keep their value. Errored writes never modify memory.
- Read data: valid on hrdata only in the DATA cycle of a read, as the full aligned 32-bit word. hrdata=0 in every other cycle, including ERR1/ERR2 and write data phases.
- Read-after-write: a read must return the result of all previously completed writes. This includes a write committing on the same edge that accepts the read (back-to-back, same word). Forward the merged bytes.
- Memory contents are not reset; reading an unwritten word returns undefined data.

## Timing
- Reset (hreset=1 at an edge): state=IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0. An in-flight transfer is abandoned; a pending write is not committed.
- OKAY latency: the data phase lasts WAIT_STATES+1 cycles after the accept edge. hreadyout is low for exactly WAIT_STATES cycles, then high for one cycle.
- ERROR: exactly 2 data-phase cycles regardless of WAIT_STATES (ERR1 then ERR2).
- Pipelining: a new address phase may be accepted at the edge ending DATA or ERR2. Back-to-back transfers with WAIT_STATES=0 complete one per cycle.
- While hreadyout=0 the slave ignores hsel/htrans (hready is low), and the captured address is held.
- An address phase aimed at another slave (hsel=0) while this slave is in DATA does not disturb the completion of this slave's data phase.

## Test plan
- Reset + idle:
  - hreset high 2 cycles then low, hsel=0 → hreadyout=1, hresp=0, hrdata=0 on every cycle.
- WAIT_STATES=0, back-to-back word traffic:
  - Write 0xDEADBEEF to 0x04, then immediately read 0x04 → read DATA cycle gives hrdata=0xDEADBEEF; hreadyout never low.
- WAIT_STATES=3, single read:
  - Read of word 0x10 → hreadyout 0,0,0,1 over the 4 data-phase cycles; hrdata valid only in the 4th cycle.
- Byte/halfword lane writes:
  - Word 0x11223344 to 0x08.
  - Byte 0xAA at 0x09, hwdata=0x0000AA00.
  - Halfword 0x5566 at 0x0A, hwdata=0x55660000.
  - Then read 0x08 → 0x5566AA44.
- ERROR cases:
  - Word write at 0x02, then halfword read at 0x01, then hsize=3 → each gives cycle 1 hreadyout=0/hresp=1 and cycle 2 hreadyout=1/hresp=1.
  - Memory at 0x00 unchanged.
- Reset mid-transfer:
  - WAIT_STATES=2; hreset asserted during the first WAIT cycle of a write of 0x12345678 to 0x0C → next cycle hreadyout=1, hresp=0.
  - A subsequent read of 0x0C returns its prior value.

Source files
------------

// File: rtl/ahb_mem_slave.sv
// AHB-Lite word-organised SRAM slave with a fixed number of wait states before
// every OKAY completion and the two-cycle ERROR response for illegal size/alignment.
module ahb_mem_slave #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);
  localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  CntLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [1:0]            size_q, size_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           mem_q [Depth];

  logic                  accept;
  logic                  req_err;
  logic                  commit;
  logic [3:0]            wr_be;
  logic [ADDR_WIDTH-1:0] req_word;
  logic [ADDR_WIDTH-1:0] cur_word;
  logic                  unused_inputs;

  // hreadyout gating keeps a stray hready from restarting an in-flight transfer.
  assign accept   = hsel & htrans[1] & hready & hreadyout;
  assign req_err  = (hsize > 3'd2) | ((hsize == 3'd1) & haddr[0]) |
                    ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
  assign commit   = (state_q == StData) & write_q;
  assign req_word = haddr[ADDR_WIDTH+1:2];
  assign cur_word = addr_q[ADDR_WIDTH+1:2];

  assign unused_inputs = ^{haddr[31:ADDR_WIDTH+2], htrans[0]};

  always_comb begin
    wr_be = 4'b0000;
    unique case (size_q)
      2'd0:    wr_be = 4'b0001 << addr_q[1:0];
      2'd1:    wr_be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wr_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StWait: begin
        if (cnt_q == 4'd0) state_d = StData;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StErr1: state_d = StErr2;
      default: begin
        state_d = StIdle;
        if (accept) begin
          if (req_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES == 0) begin
            state_d = StData;
          end else begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end
        end
      end
    endcase
    if (accept) begin
      addr_d  = haddr[ADDR_WIDTH+1:0];
      write_d = hwrite;
      size_d  = hsize[1:0];
      // Read data is sampled at accept; merge a write to the same word committing now.
      rdata_d = mem_q[req_word];
      if (commit && (cur_word == req_word)) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be[b]) rdata_d[8*b +: 8] = hwdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    unique case (state_q)
      StWait: hreadyout = 1'b0;
      StErr1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      StErr2: hresp = 1'b1;
      StData: begin
        if (!write_q) hrdata = rdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset; a reset during DATA drops the pending write.
  always_ff @(posedge hclk) begin
    if (!hreset && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[cur_word][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Self-checking bench: four slaves with 0..3 wait states, each on its own bus,
// checked cycle by cycle against a byte-lane memory model.
module tb_ahb_mem_slave;
  localparam int unsigned AW    = 6;
  localparam int unsigned NDUT  = 4;
  localparam int unsigned NWORD = 1 << AW;

  logic            hclk = 1'b0;
  logic            hreset;
  logic [NDUT-1:0] hsel_v;
  logic [31:0]     haddr;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize;
  logic [31:0]     hwdata;
  logic [31:0]     hrdata_v [NDUT];
  logic [NDUT-1:0] hreadyout_v;
  logic [NDUT-1:0] hresp_v;

  always #5 hclk = ~hclk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    ahb_mem_slave #(
      .ADDR_WIDTH (AW),
      .WAIT_STATES(gi)
    ) u_dut (
      .hclk     (hclk),
      .hreset   (hreset),
      .hsel     (hsel_v[gi]),
      .haddr    (haddr),
      .htrans   (htrans),
      .hwrite   (hwrite),
      .hsize    (hsize),
      .hwdata   (hwdata),
      .hready   (hreadyout_v[gi]),
      .hrdata   (hrdata_v[gi]),
      .hreadyout(hreadyout_v[gi]),
      .hresp    (hresp_v[gi])
    );
  end

  int          n_cmp;
  int          n_fail;
  logic [31:0] mem_m [NDUT][NWORD];

  // Transfer whose data phase is in progress (previous address phase).
  bit          p_valid;
  bit          p_err;
  bit          p_write;
  logic [31:0] p_addr;
  logic [2:0]  p_size;
  logic [31:0] p_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
    return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] off, input logic [2:0] s);
    logic [31:0] r;
    int          o;
    int          nb;
    r  = old;
    o  = int'(off);
    nb = 1 << s;
    for (int b = 0; b < 4; b++) begin
      if (b >= o && b < o + nb) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // Present one address phase (or a non-accepted one) to slave k while finishing the
  // pending data phase; returns its data-phase length and the hrdata of its last cycle.
  task automatic step(input int k, input bit nv, input logic [31:0] na, input bit nw,
                      input logic [2:0] ns, input logic [31:0] nwd,
                      output int ncyc, output logic [31:0] last_rd);
    int          i;
    bit          done;
    bit          exp_rdy;
    bit          exp_resp;
    bit          tb;
    logic [31:0] exp_rd;
    hsel_v = '0;
    tb     = 1'($urandom_range(1));
    if (nv) begin
      hsel_v[k] = 1'b1;
      htrans    = {1'b1, tb};
    end else if ($urandom_range(1) == 1) begin
      htrans = {1'b1, tb};
    end else begin
      hsel_v[k] = 1'($urandom_range(1));
      htrans    = {1'b0, tb};
    end
    haddr  = na;
    hwrite = nw;
    hsize  = ns;
    hwdata = p_wdata;
    i      = 0;
    done   = 1'b0;
    while (!done) begin
      if (!p_valid) begin
        exp_rdy  = 1'b1;
        exp_resp = 1'b0;
      end else if (p_err) begin
        exp_rdy  = (i == 1);
        exp_resp = 1'b1;
      end else begin
        exp_rdy  = (i == k);
        exp_resp = 1'b0;
      end
      exp_rd = (p_valid && !p_err && !p_write && exp_rdy) ? mem_m[k][p_addr[AW+1:2]] : 32'h0;
      chk($sformatf("hreadyout[%0d]", k), {31'b0, hreadyout_v[k]}, {31'b0, exp_rdy});
      chk($sformatf("hresp[%0d]", k), {31'b0, hresp_v[k]}, {31'b0, exp_resp});
      chk($sformatf("hrdata[%0d]", k), hrdata_v[k], exp_rd);
      last_rd = hrdata_v[k];
      done    = (hreadyout_v[k] === 1'b1) || (i >= 20);
      if (i >= 20) begin
        n_cmp++;
        n_fail++;
        $error("FAIL timeout[%0d]: hreadyout low for %0d cycles, want at most %0d", k, i, k);
      end
      @(posedge hclk);
      #1;
      i++;
    end
    ncyc = i;
    if (p_valid && !p_err && p_write)
      mem_m[k][p_addr[AW+1:2]] = merge(mem_m[k][p_addr[AW+1:2]], p_wdata, p_addr[1:0], p_size);
    p_valid = nv;
    p_err   = is_err(na, ns);
    p_write = nw;
    p_addr  = na;
    p_size  = ns;
    p_wdata = nw ? nwd : $urandom();
  endtask

  task automatic flush(input int k, output int ncyc, output logic [31:0] rd);
    step(k, 1'b0, $urandom(), 1'b0, 3'd2, 32'h0, ncyc, rd);
  endtask

  task automatic chk_all_idle(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("%s hreadyout[%0d]", tag, k), {31'b0, hreadyout_v[k]}, 32'h1);
      chk($sformatf("%s hresp[%0d]", tag, k), {31'b0, hresp_v[k]}, 32'h0);
      chk($sformatf("%s hrdata[%0d]", tag, k), hrdata_v[k], 32'h0);
    end
  endtask

  initial begin
    int          nc;
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] save;
    logic [2:0]  s;
    n_cmp   = 0;
    n_fail  = 0;
    p_valid = 1'b0;
    p_err   = 1'b0;
    p_write = 1'b0;
    p_addr  = '0;
    p_size  = '0;
    p_wdata = '0;
    hreset  = 1'b1;
    hsel_v  = '0;
    htrans  = 2'b00;
    haddr   = '0;
    hwrite  = 1'b0;
    hsize   = 3'd0;
    hwdata  = '0;

    // Reset and idle.
    repeat (2) begin
      @(posedge hclk);
      #1;
      chk_all_idle("reset");
    end
    hreset = 1'b0;
    repeat (2) begin
      @(posedge hclk);
      #1;
      chk_all_idle("idle");
    end

    // Fill every word of every slave; upper address bits are noise and must be ignored.
    for (int k = 0; k < NDUT; k++) begin
      for (int w = 0; w < NWORD; w++) begin
        a = $urandom();
        a[AW+1:0] = {w[AW-1:0], 2'b00};
        step(k, 1'b1, a, 1'b1, 3'd2, $urandom(), nc, rd);
      end
      flush(k, nc, rd);
    end

    // Zero wait states, back-to-back write then read of the same word.
    step(0, 1'b1, 32'h04, 1'b1, 3'd2, 32'hDEADBEEF, nc, rd);
    step(0, 1'b1, 32'h04, 1'b0, 3'd2, 32'h0, nc, rd);
    flush(0, nc, rd);
    chk("ws0 raw data", rd, 32'hDEADBEEF);
    chk("ws0 raw cycles", nc, 32'd1);

    // Three wait states, single read.
    step(3, 1'b1, 32'h10, 1'b0, 3'd2, 32'h0, nc, rd);
    flush(3, nc, rd);
    chk("ws3 read cycles", nc, 32'd4);
    chk("ws3 read data", rd, mem_m[3][4]);

    // Byte and halfword lane writes, pipelined.
    step(1, 1'b1, 32'h08, 1'b1, 3'd2, 32'h11223344, nc, rd);
    step(1, 1'b1, 32'h09, 1'b1, 3'd0, 32'h0000AA00, nc, rd);
    step(1, 1'b1, 32'h0A, 1'b1, 3'd1, 32'h55660000, nc, rd);
    step(1, 1'b1, 32'h08, 1'b0, 3'd2, 32'h0, nc, rd);
    flush(1, nc, rd);
    chk("lane merge", rd, 32'h5566AA44);

    // Error responses, with and without wait states.
    for (int k = 0; k < NDUT; k += 2) begin
      save = mem_m[k][0];
      step(k, 1'b1, 32'h02, 1'b1, 3'd2, 32'hFFFFFFFF, nc, rd);
      step(k, 1'b1, 32'h01, 1'b0, 3'd1, 32'h0, nc, rd);
      chk($sformatf("err word write cycles[%0d]", k), nc, 32'd2);
      step(k, 1'b1, 32'h00, 1'b0, 3'd3, 32'h0, nc, rd);
      chk($sformatf("err half read cycles[%0d]", k), nc, 32'd2);
      flush(k, nc, rd);
      chk($sformatf("err size3 cycles[%0d]", k), nc, 32'd2);
      step(k, 1'b1, 32'h00, 1'b0, 3'd2, 32'h0, nc, rd);
      flush(k, nc, rd);
      chk($sformatf("err no write[%0d]", k), rd, save);
    end

    // Reset during the first wait cycle of a write abandons it.
    save      = mem_m[2][3];
    hsel_v    = 4'b0100;
    htrans    = 2'b10;
    haddr     = 32'h0C;
    hwrite    = 1'b1;
    hsize     = 3'd2;
    hwdata    = $urandom();
    @(posedge hclk);
    #1;
    chk("mid-reset wait", {31'b0, hreadyout_v[2]}, 32'h0);
    hsel_v    = '0;
    htrans    = 2'b00;
    hwdata    = 32'h12345678;
    hreset    = 1'b1;
    @(posedge hclk);
    #1;
    hreset    = 1'b0;
    chk_all_idle("mid-reset");
    step(2, 1'b1, 32'h0C, 1'b0, 3'd2, 32'h0, nc, rd);
    flush(2, nc, rd);
    chk("mid-reset no commit", rd, save);

    // Random traffic, including idle/busy/other-slave cycles and illegal requests.
    for (int k = 0; k < NDUT; k++) begin
      for (int n = 0; n < 80; n++) begin
        a = $urandom();
        case ($urandom_range(9))
          0, 1, 2: s = 3'd0;
          3, 4, 5: s = 3'd1;
          6, 7, 8: s = 3'd2;
          default: s = 3'(3 + $urandom_range(4));
        endcase
        if ($urandom_range(3) != 0 && s <= 3'd2) a = a & ~((32'd1 << s) - 32'd1);
        step(k, ($urandom_range(3) != 0), a, 1'($urandom_range(1)), s, $urandom(), nc, rd);
      end
      flush(k, nc, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
